// File: rtl/time_disp_pkg.sv
// Shared field layout, segment patterns and converter state encoding for the
// time display driver and its serial BCD converter.
package time_disp_pkg;

    localparam int H_W  = 5;
    localparam int M_W  = 6;
    localparam int S_W  = 6;
    localparam int MS_W = 10;

    localparam int MS_LSB = 0;
    localparam int S_LSB  = MS_LSB + MS_W;
    localparam int M_LSB  = S_LSB + S_W;
    localparam int H_LSB  = M_LSB + M_W;
    localparam int TIME_W = H_LSB + H_W;

    localparam int NUM_DIGITS = 8;
    localparam int BCD_W      = 16;

    // Active-low cathodes, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_NEXT,
        ST_COMMIT
    } conv_state_t;

    typedef enum logic [1:0] {
        FLD_MS,
        FLD_S,
        FLD_M,
        FLD_H
    } field_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_serial_converter.sv
// Serial double-dabble engine: one load cycle, then one field bit per clock,
// producing four BCD nibbles for a field of up to MS_W bits.
module bcd_serial_converter
    import time_disp_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [MS_W-1:0]   i_field,
    input  logic [3:0]        i_width,
    output logic              o_done,
    output logic [BCD_W-1:0]  o_bcd
);

    logic [BCD_W-1:0] r_acc;
    logic [MS_W-1:0]  r_sh;
    logic [3:0]       r_cnt;

    logic [BCD_W-1:0] w_adj;
    logic [MS_W-1:0]  w_aligned;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // The field is left-aligned so its MSB always leaves from the top of r_sh.
    always_comb begin
        w_aligned = i_field << (4'(MS_W) - i_width);
        w_adj     = '0;
        for (int i = 0; i < BCD_W / 4; i++) begin
            w_adj[4*i +: 4] = add3(r_acc[4*i +: 4]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_acc <= '0;
            r_sh  <= w_aligned;
            r_cnt <= i_width;
        end else if (r_cnt != 4'd0) begin
            r_acc <= BCD_W'({w_adj, r_sh[MS_W-1]});
            r_sh  <= {r_sh[MS_W-2:0], 1'b0};
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Asserted during the final shift; o_bcd holds the result from the next cycle.
    assign o_done = (r_cnt == 4'd1);
    assign o_bcd  = r_acc;

endmodule

// File: rtl/time_display_driver.sv
// Snapshots the packed stopwatch time once per scan frame, converts it to BCD
// and drives an 8-digit multiplexed common-anode display as HH.MM.SS.cc.
module time_display_driver
    import time_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] disp_time,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        conv_busy
);

    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam int               SEL_W    = $clog2(NUM_DIGITS);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_div;
    logic [SEL_W-1:0]        r_sel;
    logic                    r_first;
    logic [TIME_W-1:0]       r_snap;
    conv_state_t             r_state;
    field_t                  r_fld;
    logic [BCD_W-1:0]        r_ms_bcd;
    logic [7:0]              r_s_bcd;
    logic [7:0]              r_m_bcd;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [7:0]              r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;

    conv_state_t             w_state_nxt;
    logic                    w_div_wrap;
    logic                    w_frame_wrap;
    logic                    w_start_req;
    logic                    w_start;
    logic                    w_conv_start;
    logic                    w_conv_done;
    logic [MS_W-1:0]         w_conv_field;
    logic [3:0]              w_conv_width;
    logic [BCD_W-1:0]        w_conv_bcd;
    logic [7:0]              w_ms_disp;
    logic [3:0]              w_nib;

    assign w_div_wrap   = (r_div == DIV_LAST);
    assign w_frame_wrap = w_div_wrap && (r_sel == SEL_LAST);
    assign w_start_req  = r_first || w_frame_wrap;
    assign w_start      = w_start_req && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div   <= '0;
            r_sel   <= '0;
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
            if (w_div_wrap) begin
                r_div <= '0;
                r_sel <= r_sel + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NEXT both stores the finished field and loads the following one, so the
    // four loads cost one cycle each and the whole pass takes 32 cycles.
    always_comb begin
        w_state_nxt  = r_state;
        w_conv_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_req) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_conv_start = 1'b1;
                w_state_nxt  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_conv_done) w_state_nxt = (r_fld == FLD_H) ? ST_COMMIT : ST_NEXT;
            end
            ST_NEXT: begin
                w_conv_start = 1'b1;
                w_state_nxt  = ST_SHIFT;
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_conv_field = r_snap[MS_LSB +: MS_W];
        w_conv_width = 4'(MS_W);
        case (r_fld)
            FLD_S: begin
                w_conv_field = MS_W'(r_snap[S_LSB +: S_W]);
                w_conv_width = 4'(S_W);
            end
            FLD_M: begin
                w_conv_field = MS_W'(r_snap[M_LSB +: M_W]);
                w_conv_width = 4'(M_W);
            end
            FLD_H: begin
                w_conv_field = MS_W'(r_snap[H_LSB +: H_W]);
                w_conv_width = 4'(H_W);
            end
            default: begin
                w_conv_field = r_snap[MS_LSB +: MS_W];
                w_conv_width = 4'(MS_W);
            end
        endcase
    end

    bcd_serial_converter u_conv (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_start (w_conv_start),
        .i_field (w_conv_field),
        .i_width (w_conv_width),
        .o_done  (w_conv_done),
        .o_bcd   (w_conv_bcd)
    );

    // A nonzero thousands nibble means ms >= 1000, which saturates to "99".
    assign w_ms_disp = (r_ms_bcd[15:12] != 4'd0) ? 8'h99 : r_ms_bcd[11:4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snap   <= '0;
            r_fld    <= FLD_MS;
            r_ms_bcd <= '0;
            r_s_bcd  <= '0;
            r_m_bcd  <= '0;
            r_disp   <= '0;
        end else begin
            if (w_start) begin
                r_snap <= disp_time;
                r_fld  <= FLD_MS;
            end else if ((r_state == ST_SHIFT) && w_conv_done) begin
                case (r_fld)
                    FLD_MS:  r_fld <= FLD_S;
                    FLD_S:   r_fld <= FLD_M;
                    default: r_fld <= FLD_H;
                endcase
            end
            if (r_state == ST_NEXT) begin
                case (r_fld)
                    FLD_S:   r_ms_bcd <= w_conv_bcd;
                    FLD_M:   r_s_bcd  <= w_conv_bcd[7:0];
                    default: r_m_bcd  <= w_conv_bcd[7:0];
                endcase
            end
            if (r_state == ST_COMMIT) begin
                r_disp <= {w_conv_bcd[7:0], r_m_bcd, r_s_bcd, w_ms_disp};
            end
        end
    end

    assign w_nib = r_disp[{r_sel, 2'b00} +: 4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 8'hFF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(8'd1 << r_sel);
            r_seg <= seg_decode(w_nib);
            r_dp  <= !((r_sel == 3'd6) || (r_sel == 3'd4) || (r_sel == 3'd2));
        end
    end

    assign an        = r_an;
    assign seg       = r_seg;
    assign dp        = r_dp;
    assign conv_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_time_display_driver.sv
// Directed bench for time_display_driver with a short scan divider so whole
// frames and conversions fit in a few hundred cycles.
module tb_time_display_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] disp_time;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        conv_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    time_display_driver #(.SCAN_DIV(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .disp_time (disp_time),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .conv_busy (conv_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    function automatic logic [26:0] pack(input int h, input int m, input int s, input int ms);
        logic [4:0] hv;
        logic [5:0] mv;
        logic [5:0] sv;
        logic [9:0] msv;
        hv  = 5'(h);
        mv  = 6'(m);
        sv  = 6'(s);
        msv = 10'(ms);
        return {hv, mv, sv, msv};
    endfunction

    function automatic int an_digit();
        int idx;
        idx = 0;
        for (int j = 7; j >= 0; j--) begin
            if (an[j] == 1'b0) idx = j;
        end
        return idx;
    endfunction

    task automatic wait_busy_rise(input string tag);
        logic prev;
        bit   found;
        found = 1'b0;
        @(negedge clk);
        prev = conv_busy;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (!prev && conv_busy) found = 1'b1;
            prev = conv_busy;
        end
        check(tag, found, 1);
    endtask

    // Entered on the first sample where a conversion should be busy; counts
    // busy cycles and confirms the displayed digits hold the given value.
    task automatic track_conv(input string tag, input logic [31:0] hold);
        int cnt;
        int bad;
        int d;
        cnt = 0;
        bad = 0;
        check($sformatf("%s_busy_first", tag), conv_busy, 1);
        for (int i = 0; i < 40 && conv_busy; i++) begin
            cnt++;
            d = an_digit();
            if (seg !== seg_of(hold[4*d +: 4])) bad++;
            @(negedge clk);
        end
        check($sformatf("%s_busy_len", tag), cnt, 32);
        check($sformatf("%s_hold_bad", tag), bad, 0);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] nibs);
        logic [7:0] prev;
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        bit         moved;
        int         d0;
        int         d;
        moved = 1'b0;
        @(negedge clk);
        prev = an;
        for (int k = 0; k < 20 && !moved; k++) begin
            @(negedge clk);
            if (an !== prev) moved = 1'b1;
        end
        check($sformatf("%s_align", tag), moved, 1);
        d0 = an_digit();
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            d      = (d0 + i / 8) % 8;
            exp_an = ~(8'd1 << d);
            if (i % 8 == 0 || i % 8 == 7)
                check($sformatf("%s_an_d%0d_c%0d", tag, d, i % 8), an, exp_an);
            if (i % 8 == 3) begin
                exp_seg = seg_of(nibs[4*d +: 4]);
                exp_dp  = (d == 2 || d == 4 || d == 6) ? 1'b0 : 1'b1;
                check($sformatf("%s_seg_d%0d", tag, d), seg, exp_seg);
                check($sformatf("%s_dp_d%0d", tag, d), dp, exp_dp);
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        disp_time = '0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_busy", conv_busy, 1'b0);

        reset = 1'b1;
        @(negedge clk);
        check("t1_an_first", an, 8'hFE);
        track_conv("t1", 32'h00000000);
        check_frame("t1_zero", 32'h00000000);

        disp_time = pack(12, 34, 56, 789);
        repeat (140) @(negedge clk);
        check_frame("t2", 32'h12345678);

        wait_busy_rise("t3_rise_a");
        disp_time = pack(1, 2, 3, 40);
        track_conv("t3_a", 32'h12345678);
        wait_busy_rise("t3_rise_b");
        track_conv("t3_b", 32'h12345678);
        check_frame("t3_new", 32'h01020304);

        disp_time = pack(31, 63, 0, 1023);
        repeat (140) @(negedge clk);
        check_frame("t4", 32'h31630099);

        disp_time = pack(0, 60, 9, 1000);
        repeat (140) @(negedge clk);
        check_frame("t4b", 32'h00600999);

        disp_time = pack(23, 59, 59, 999);
        repeat (140) @(negedge clk);
        check_frame("t6", 32'h23595999);

        wait_busy_rise("t5_rise");
        repeat (14) @(negedge clk);
        check("t5_busy_mid", conv_busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t5_rst_an", an, 8'hFF);
        check("t5_rst_seg", seg, 7'h7F);
        check("t5_rst_busy", conv_busy, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_an_first", an, 8'hFE);
        track_conv("t5", 32'h00000000);
        check_frame("t5_new", 32'h23595999);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/time_display_driver.md
Name: time_display_driver

Overview:
Downstream consumer of the stopwatch's packed time word. The word is disp_time = {h[26:22], m[21:16], s[15:10], ms[9:0]}.
- Once per scan frame, the block snapshots the word and converts each field to BCD with a serial double-dabble engine.
- It then drives an 8-digit, time-multiplexed, common-anode 7-segment display showing HH.MM.SS.cc, where cc = ms/10 truncated.

Parameters:
SCAN_DIV, 100000, clk cycles each digit is held; legal range >= 8.

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
disp_time  in  27  packed time {h,m,s,ms}; sampled only at snapshot
an  out  8  digit anodes, active-low, one-hot; an[7] = leftmost digit
seg  out  7  segment cathodes, active-low; seg[0]=a … seg[6]=g
dp  out  1  decimal point, active-low
conv_busy  out  1  high while the BCD conversion is in progress

Behaviour:
Reset (reset=0, asynchronous):
- div_cnt=0, digit_sel=0, display register = all digits 0, converter idle.
- Outputs: an=8'hFF, seg=7'h7F, dp=1, conv_busy=0.

Scan:
- div_cnt counts 0..SCAN_DIV-1 and wraps.
- On each wrap, digit_sel advances mod 8.
- an, seg and dp are registered: they reflect digit_sel one cycle after digit_sel changes.

Digit map (digit_sel → value):
- 7 = H tens, 6 = H units
- 5 = M tens, 4 = M units
- 3 = S tens, 2 = S units
- 1 = ms hundreds, 0 = ms tens
- dp=0 on digits 6, 4 and 2; dp=1 on all others.
- No leading-zero blanking.

Segment decode:
- 0..9 use the standard patterns, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000.
- Codes 10..15 give blank (7'h7F).

Snapshot and start:
- A start pulse fires on the first clock after reset deassertion.
- After that, it fires on every frame wrap (digit_sel 7→0 with div_cnt wrap).
- On start, disp_time is latched into the snapshot register.
- A start request while conv_busy=1 is ignored. This cannot occur when SCAN_DIV >= 8.

Converter FSM, states IDLE → LOAD → SHIFT → NEXT → … → COMMIT → IDLE:
- Fields are processed in the order ms(10b), s(6b), m(6b), h(5b).
- LOAD takes 1 cycle per field and clears the BCD accumulator.
- SHIFT takes one cycle per field bit: add 3 to each nibble >= 5, then shift left by 1, bringing in the field MSB.
- NEXT stores the field's BCD and selects the next field.
- COMMIT copies all 8 digits into the display register in a single cycle. The display never shows mixed old and new fields.
- Total latency: start → commit = 4 LOAD + 27 SHIFT + 1 COMMIT = 32 cycles.
- conv_busy is high from the cycle after start through the COMMIT cycle inclusive.

Range rules:
- ms >= 1000: shown as "99".
- h 24..31 and m/s 60..63: shown as raw converted values, e.g. m=63 shows "63".
- Out-of-range values are not flagged.

Reset mid-conversion:
- The conversion aborts with no commit.
- The display register returns to zero.
- A new start fires on the first clock after reset release.

Decomposition:
Shared package (time_disp_pkg):
- Field widths H_W=5, M_W=6, S_W=6, MS_W=10.
- Field bit offsets within disp_time.
- NUM_DIGITS=8.
- Segment constants SEG_0..SEG_9 and SEG_BLANK.
- Converter state enum.

Sub-module: bcd_serial_converter.
- Converts a single field of up to 10 bits.
- Handshake: start / done.
- Outputs 4 BCD nibbles.
- The top level sequences the four fields through it.

Test Plan:
1. Reset hold, then release with disp_time=0 → an=8'hFF during reset; conv_busy high for 32 cycles; afterwards the display shows "00.00.00.00" and seg=7'b1000000 on every digit.
2. SCAN_DIV=8, h=12 m=34 s=56 ms=789 → the frame shows digits 1,2,3,4,5,6,7,8; an cycles 8'hFE→8'hFD→…→8'h7F, one step every 8 clk; dp=0 only while an[6], an[4] or an[2] is low.
3. Change disp_time during conversion → the display stays at the old value until COMMIT, then switches to the new snapshot atomically; no mixed frame.
4. ms=1023, h=31, m=63, s=0 → the display shows "31.63.00.99".
5. Assert reset at cycle 15 of a conversion → no commit occurs; display reads all zeros; after release, a new conversion completes 32 cycles later.
6. h=23 m=59 s=59 ms=999 → the display shows "23.59.59.99"; the ms hundreds digit decodes to 9, seg=7'b0010000.
